// File: rtl/traffic_pkg.sv
// Shared constants, state encoding and light decode for the phased traffic controller.
package traffic_pkg;

    localparam int SENSOR_W  = 8;
    localparam int GENERAL_W = 30;
    localparam int LIGHT_W   = 3;
    localparam int DEBUG_W   = 30;

    localparam logic [2:0] LIGHT_STOP  = 3'b000;
    localparam logic [2:0] LIGHT_FWD   = 3'b001;
    localparam logic [2:0] LIGHT_LEFT  = 3'b010;
    localparam logic [2:0] LIGHT_RIGHT = 3'b011;
    localparam logic [2:0] LIGHT_GO    = 3'b100;

    // sensor_light bit per approach direction
    localparam int SENSE_N = 6;
    localparam int SENSE_S = 4;
    localparam int SENSE_E = 5;
    localparam int SENSE_W = 7;

    // demand register bit order {N,S,E,W}, matching the debug field
    localparam int DMD_N = 3;
    localparam int DMD_S = 2;
    localparam int DMD_E = 1;
    localparam int DMD_W = 0;

    localparam int DBG_STATE_LSB  = 0;
    localparam int DBG_DEMAND_LSB = 3;
    localparam int DBG_CNT_LSB    = 7;
    localparam int DBG_CNT_W      = 23;

    typedef enum logic [2:0] {
        NS_GO    = 3'd0,
        NS_CLEAR = 3'd1,
        EW_GO    = 3'd2,
        EW_CLEAR = 3'd3,
        NS_LEFT  = 3'd4,
        EW_LEFT  = 3'd5
    } phase_t;

    typedef struct packed {
        logic [2:0] n;
        logic [2:0] s;
        logic [2:0] e;
        logic [2:0] w;
    } lights_t;

    function automatic lights_t decodeLights(input phase_t phase);
        lights_t l;
        l.n = LIGHT_STOP;
        l.s = LIGHT_STOP;
        l.e = LIGHT_STOP;
        l.w = LIGHT_STOP;
        case (phase)
            NS_GO: begin
                l.n = LIGHT_GO;
                l.s = LIGHT_GO;
            end
            EW_GO: begin
                l.e = LIGHT_GO;
                l.w = LIGHT_GO;
            end
            NS_LEFT: begin
                l.n = LIGHT_LEFT;
                l.s = LIGHT_LEFT;
            end
            EW_LEFT: begin
                l.e = LIGHT_LEFT;
                l.w = LIGHT_LEFT;
            end
            default: begin
                l.n = LIGHT_STOP;
                l.s = LIGHT_STOP;
                l.e = LIGHT_STOP;
                l.w = LIGHT_STOP;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_phased_if.sv
// Sensor inputs, light outputs and debug bus of one intersection controller.
interface traffic_light_phased_if;
    import traffic_pkg::*;

    logic [SENSOR_W-1:0]  sensor_light;
    logic [GENERAL_W-1:0] general_sensors;
    logic [LIGHT_W-1:0]   outN;
    logic [LIGHT_W-1:0]   outS;
    logic [LIGHT_W-1:0]   outE;
    logic [LIGHT_W-1:0]   outW;
    logic [DEBUG_W-1:0]   debug_port;

    modport master (
        output sensor_light, general_sensors,
        input  outN, outS, outE, outW, debug_port
    );

    modport slave (
        input  sensor_light, general_sensors,
        output outN, outS, outE, outW, debug_port
    );

endinterface

// File: rtl/traffic_phase_timer.sv
// Phase counter: restarts at zero on every state change, saturates, and flags phase expiry.
module traffic_phase_timer #(
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 12,
    parameter int CLEAR_TIME = 2,
    parameter int LEFT_TIME  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loadZero,
    output logic [CNT_W-1:0] count,
    output logic             minDone,
    output logic             maxDone,
    output logic             clearDone,
    output logic             leftDone
);

    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TIME - 1);
    localparam logic [CNT_W-1:0] LEFT_LAST  = CNT_W'(LEFT_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

    // Cycles spent in the current phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {CNT_W{1'b0}};
        end else if (loadZero) begin
            count <= {CNT_W{1'b0}};
        end else if (count != CNT_SAT) begin
            count <= count + CNT_W'(1'b1);
        end else begin
            count <= count;
        end
    end

    assign minDone   = (count >= MIN_LAST);
    assign maxDone   = (count >= MAX_LAST);
    assign clearDone = (count == CLEAR_LAST);
    assign leftDone  = (count == LEFT_LAST);

endmodule

// File: rtl/traffic_light_phased.sv
// Sensor-actuated two-axis intersection controller with min/max green and all-stop clearance.
// Optional protected-left phases are built when TRAFFIC_LEFT_PHASE_EN is defined.
module traffic_light_phased
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 12,
    parameter int CLEAR_TIME  = 2,
    parameter int LEFT_TIME   = 3,
    parameter int NS_LEFT_IDX = 0,
    parameter int EW_LEFT_IDX = 1,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_phased_if.slave bus
);

    phase_t           stateReg;
    phase_t           stateNext;
    logic [3:0]       demandReg;
    logic [3:0]       demandNext;
    logic [3:0]       demandSet;
    logic [3:0]       demandClear;
    lights_t          lightsReg;
    logic [CNT_W-1:0] count;
    logic             loadZero;
    logic             minDone;
    logic             maxDone;
    logic             clearDone;
    logic             leftDone;
    logic             nsDemand;
    logic             ewDemand;
    logic             nsLeftPending;
    logic             ewLeftPending;
    logic             unusedGeneral;

    traffic_phase_timer #(
        .CNT_W      (CNT_W),
        .MIN_GREEN  (MIN_GREEN),
        .MAX_GREEN  (MAX_GREEN),
        .CLEAR_TIME (CLEAR_TIME),
        .LEFT_TIME  (LEFT_TIME)
    ) timer (
        .clk       (clk),
        .rst       (rst),
        .loadZero  (loadZero),
        .count     (count),
        .minDone   (minDone),
        .maxDone   (maxDone),
        .clearDone (clearDone),
        .leftDone  (leftDone)
    );

    assign nsDemand = demandReg[DMD_N] | demandReg[DMD_S];
    assign ewDemand = demandReg[DMD_E] | demandReg[DMD_W];
    assign loadZero = (stateNext != stateReg);
    assign unusedGeneral = ^bus.general_sensors;

`ifdef TRAFFIC_LEFT_PHASE_EN
    logic nsLeftReq;
    logic ewLeftReq;

    // Left requests latch from the user sensors and are consumed when the left phase starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nsLeftReq <= 1'b0;
            ewLeftReq <= 1'b0;
        end else begin
            if (stateNext == NS_LEFT && stateReg != NS_LEFT) begin
                nsLeftReq <= 1'b0;
            end else begin
                nsLeftReq <= nsLeftReq | bus.general_sensors[NS_LEFT_IDX];
            end
            if (stateNext == EW_LEFT && stateReg != EW_LEFT) begin
                ewLeftReq <= 1'b0;
            end else begin
                ewLeftReq <= ewLeftReq | bus.general_sensors[EW_LEFT_IDX];
            end
        end
    end

    assign nsLeftPending = nsLeftReq;
    assign ewLeftPending = ewLeftReq;
`else
    assign nsLeftPending = 1'b0;
    assign ewLeftPending = 1'b0;
`endif

    // Demand latch; the axis currently served drops its own bits, and that clear beats a new set
    always_comb begin
        demandSet = {bus.sensor_light[SENSE_N], bus.sensor_light[SENSE_S],
                     bus.sensor_light[SENSE_E], bus.sensor_light[SENSE_W]};
        case (stateReg)
            NS_GO:   demandClear = 4'b1100;
            EW_GO:   demandClear = 4'b0011;
            default: demandClear = 4'b0000;
        endcase
        demandNext = (demandReg | demandSet) & ~demandClear;
    end

    // Phase sequencing from latched demand and timer expiry
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            NS_GO: begin
                if (ewDemand && ((minDone && !nsDemand) || maxDone)) begin
                    stateNext = NS_CLEAR;
                end else begin
                    stateNext = NS_GO;
                end
            end
            NS_CLEAR: begin
                if (clearDone) begin
                    stateNext = ewLeftPending ? EW_LEFT : EW_GO;
                end else begin
                    stateNext = NS_CLEAR;
                end
            end
            EW_GO: begin
                if (nsDemand && ((minDone && !ewDemand) || maxDone)) begin
                    stateNext = EW_CLEAR;
                end else begin
                    stateNext = EW_GO;
                end
            end
            EW_CLEAR: begin
                if (clearDone) begin
                    stateNext = nsLeftPending ? NS_LEFT : NS_GO;
                end else begin
                    stateNext = EW_CLEAR;
                end
            end
            NS_LEFT: begin
                if (leftDone) begin
                    stateNext = NS_GO;
                end else begin
                    stateNext = NS_LEFT;
                end
            end
            EW_LEFT: begin
                if (leftDone) begin
                    stateNext = EW_GO;
                end else begin
                    stateNext = EW_LEFT;
                end
            end
            default: stateNext = NS_GO;
        endcase
    end

    // State, demand and lights registers; lights are decoded from the next state so they track stateReg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg  <= NS_GO;
            demandReg <= 4'b0000;
            lightsReg <= decodeLights(NS_GO);
        end else begin
            stateReg  <= stateNext;
            demandReg <= demandNext;
            lightsReg <= decodeLights(stateNext);
        end
    end

    assign bus.outN = lightsReg.n;
    assign bus.outS = lightsReg.s;
    assign bus.outE = lightsReg.e;
    assign bus.outW = lightsReg.w;
    assign bus.debug_port = {DBG_CNT_W'(count), demandReg, stateReg};

endmodule
